sha256_compress_engine: RTL and testbench

- Iterative SHA-256 compression core: consumes the 64-word message schedule (W0..W63) one word per accepted handshake and performs one round per word.
- At the end it adds the working variables to the incoming chaining value and presents the new 256-bit hash state.
- Sits downstream of the message-schedule/extension logic in the scrypt hashing datapath. It is the consumer of the W stream that the schedule side produces.

---
 rtl/sha256_compress_engine.sv | 130 +++++++++++++
 tb/tb_sha256_compress_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_engine.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compress_engine
// Brief    : Iterative SHA-256 compression, one round per accepted W word.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_compress_engine #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic [31:0]  w_in,
    input  logic         w_valid,
    output logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] h_out
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ROUND = 2'd1;
    localparam logic [1:0] c_S_FINAL = 2'd2;

    localparam logic [5:0] c_LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [1:0]   r_state;
    logic [5:0]   r_t;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0] r_hs;
    logic [255:0] r_hout;
    logic         r_done;

    logic [31:0]  w_s0, w_s1, w_ch, w_maj, w_t1, w_t2, w_k;
    logic         w_accept;

    // Handshake signals depend on state only, never on w_valid.
    assign w_ready  = (r_state == c_S_ROUND);
    assign busy     = (r_state != c_S_IDLE);
    assign done     = r_done;
    assign h_out    = r_hout;
    assign w_accept = w_valid && w_ready;

    assign w_k   = c_K[r_t];
    assign w_s1  = {r_e[5:0], r_e[31:6]} ^ {r_e[10:0], r_e[31:11]} ^ {r_e[24:0], r_e[31:25]};
    assign w_s0  = {r_a[1:0], r_a[31:2]} ^ {r_a[12:0], r_a[31:13]} ^ {r_a[21:0], r_a[31:22]};
    assign w_ch  = (r_e & r_f) ^ (~r_e & r_g);
    assign w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
    assign w_t1  = r_h + w_s1 + w_ch + w_k + w_in;
    assign w_t2  = w_s0 + w_maj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_t     <= 6'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_c     <= 32'd0;
            r_d     <= 32'd0;
            r_e     <= 32'd0;
            r_f     <= 32'd0;
            r_g     <= 32'd0;
            r_h     <= 32'd0;
            r_hs    <= 256'd0;
            r_hout  <= 256'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_hs <= h_in;
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= h_in;
                        r_t     <= 6'd0;
                        r_state <= c_S_ROUND;
                    end
                end
                c_S_ROUND: begin
                    if (w_accept) begin
                        r_h <= r_g;
                        r_g <= r_f;
                        r_f <= r_e;
                        r_e <= r_d + w_t1;
                        r_d <= r_c;
                        r_c <= r_b;
                        r_b <= r_a;
                        r_a <= w_t1 + w_t2;
                        r_t <= r_t + 6'd1;
                        if (r_t == c_LAST_T) begin
                            r_state <= c_S_FINAL;
                        end
                    end
                end
                c_S_FINAL: begin
                    r_hout <= {r_hs[255:224] + r_a, r_hs[223:192] + r_b,
                               r_hs[191:160] + r_c, r_hs[159:128] + r_d,
                               r_hs[127:96]  + r_e, r_hs[95:64]   + r_f,
                               r_hs[63:32]   + r_g, r_hs[31:0]    + r_h};
                    r_done  <= 1'b1;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compress_engine
// Brief    : Directed known-answer bench for sha256_compress_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_compress_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] h_in;
    logic [31:0]  w_in;
    logic         w_valid;
    logic         w_ready;
    logic         busy;
    logic         done;
    logic [255:0] h_out;

    sha256_compress_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .h_in    (h_in),
        .w_in    (w_in),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .busy    (busy),
        .done    (done),
        .h_out   (h_out)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] c_IV   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_MID2 = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] c_DIG2 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] c_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [511:0] c_BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] c_BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] c_BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_BLK_2B    = {480'h0, 32'h000001c0};

    typedef struct packed {
        logic [511:0] blk;
        logic [255:0] hin;
        logic [255:0] exp;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] sched [64];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message-schedule expansion of one 512-bit block into sched[0..63].
    task automatic load_sched(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            sched[i] = (rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10))
                     + sched[i-7]
                     + (rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3))
                     + sched[i-16];
        end
    endtask

    // mode 0: w_valid always high; 1: random stalls; 2: extra starts and h_in churn mid-block.
    // Entered just after an edge with the DUT idle (possibly in its done cycle);
    // returns just after the edge that raises done.
    task automatic run_block(input string name, input logic [255:0] hin, input logic [255:0] exp,
                             input int mode, output logic [255:0] hres);
        int idx;
        int cyc;
        int lat;
        int bad;
        bit hs;
        h_in    = hin;
        start   = 1'b1;
        w_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; idx = 0; cyc = 0; bad = 0;
        while (idx < 64 && cyc < 1000) begin
            w_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            w_in    = sched[idx];
            if (mode == 2) begin
                start = (cyc == 10 || cyc == 40);
                h_in  = ~hin;
            end
            if (!w_ready || !busy || done) bad++;
            hs = w_valid && w_ready;
            @(posedge clk); #1;
            lat++;
            cyc++;
            if (hs) idx++;
        end
        start = 1'b0;
        chk({name, " words accepted"}, 256'(idx), 256'd64);
        chk({name, " round flags"}, 256'(bad), 256'd0);
        w_valid = 1'b1;
        w_in    = 32'hdeadbeef;
        chk({name, " final {ready,busy,done}"}, {253'd0, w_ready, busy, done}, 256'b010);
        @(posedge clk); #1;
        lat++;
        w_valid = 1'b0;
        chk({name, " done"}, {255'd0, done}, 256'd1);
        chk({name, " h_out"}, h_out, exp);
        if (mode != 1) chk({name, " latency"}, 256'(lat), 256'd66);
        hres = h_out;
    endtask

    initial begin
        logic [255:0] res;
        int           bad;

        vecs[0] = '{blk: c_BLK_ABC,   hin: c_IV,   exp: c_ABC};
        vecs[1] = '{blk: c_BLK_EMPTY, hin: c_IV,   exp: c_EMPTY};
        vecs[2] = '{blk: c_BLK_2A,    hin: c_IV,   exp: c_MID2};
        vecs[3] = '{blk: c_BLK_2B,    hin: c_MID2, exp: c_DIG2};

        rst = 1'b1; start = 1'b0; w_valid = 1'b0; h_in = '0; w_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset {ready,busy,done}", {253'd0, w_ready, busy, done}, 256'd0);
        chk("reset h_out", h_out, 256'd0);
        rst = 1'b0;

        // Words offered with no start must not be taken.
        bad = 0;
        w_valid = 1'b1;
        h_in    = c_IV;
        for (int i = 0; i < 20; i++) begin
            w_in = $urandom;
            @(posedge clk); #1;
            if (w_ready || busy || done || h_out != 256'd0) bad++;
        end
        w_valid = 1'b0;
        chk("idle ignores w_valid", 256'(bad), 256'd0);

        for (int v = 0; v < 4; v++) begin
            load_sched(vecs[v].blk);
            run_block($sformatf("vec%0d", v), vecs[v].hin, vecs[v].exp, 0, res);
        end
        repeat (2) @(posedge clk);
        #1;

        load_sched(c_BLK_ABC);
        run_block("abc stall", c_IV, c_ABC, 1, res);
        repeat (3) @(posedge clk);
        #1;

        run_block("abc extra start", c_IV, c_ABC, 2, res);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        chk("extra start single done", 256'(bad), 256'd0);

        // Abort a block after 30 words; reset must clear everything.
        h_in = c_IV; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; w_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            w_in = sched[i];
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort {ready,busy,done}", {253'd0, w_ready, busy, done}, 256'd0);
        chk("abort h_out", h_out, 256'd0);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            w_in = sched[(i + 30) % 64];
            @(posedge clk); #1;
            if (done || busy || w_ready) bad++;
        end
        w_valid = 1'b0;
        chk("abort no done", 256'(bad), 256'd0);
        run_block("abc after abort", c_IV, c_ABC, 0, res);
        repeat (2) @(posedge clk);
        #1;

        load_sched(c_BLK_2A);
        run_block("b2b blk1", c_IV, c_MID2, 0, res);
        load_sched(c_BLK_2B);
        run_block("b2b blk2", res, c_DIG2, 0, res);
        @(posedge clk); #1;
        chk("done is one cycle", {255'd0, done}, 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
